mult_div_unit: RTL and testbench

Iterative multiply/divide unit for the pipelined MIPS datapath. It executes MULT, MULTU, DIV and DIVU, one operand bit per cycle, and holds the 64-bit result in HI/LO registers. result_o feeds a data input of the 4-to-1 write-back select multiplexer, which covers MFHI/MFLO. busy_o drives the hazard unit's stall logic.

---
 rtl/mult_div_unit.sv | 156 +++++++++++++++
 tb/tb_mult_div_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mult_div_unit
//  Purpose  : Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
//             One operand bit per cycle (shift-add multiply, restoring
//             divide), sign fix-up applied on the final iteration edge.
//  Revision : 1.0  initial release
// ============================================================================
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic             hilo_sel_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0]    c_IDLE    = 2'd0;
    localparam logic [1:0]    c_RUN     = 2'd1;
    localparam logic [1:0]    c_DONE    = 2'd2;
    localparam logic [CW-1:0] c_LAST    = CW'(WIDTH - 1);
    localparam logic [CW-1:0] c_CNT_ONE = CW'(1);

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_op_div;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_div0;
    logic [WIDTH-1:0] r_src1;
    logic [WIDTH-1:0] r_a;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0] r_acc;    // product high half / partial remainder
    logic [WIDTH-1:0] r_shf;    // multiplier -> product low / dividend -> quotient
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_accept;
    logic [WIDTH-1:0] w_abs1;
    logic [WIDTH-1:0] w_abs2;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_div_rem_sh;
    logic [WIDTH:0]   w_div_diff;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_nxt_acc;
    logic [WIDTH-1:0] w_nxt_shf;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0] w_fin_hi;
    logic [WIDTH-1:0] w_fin_lo;

    // A new op is taken in IDLE, and in DONE so back-to-back ops need no bubble
    assign w_accept = start_i && ((r_state == c_IDLE) || (r_state == c_DONE));

    // Signed ops iterate on magnitudes; the most negative value maps onto itself
    assign w_abs1 = (op_i[0] && src1_i[WIDTH-1]) ? -src1_i : src1_i;
    assign w_abs2 = (op_i[0] && src2_i[WIDTH-1]) ? -src2_i : src2_i;

    // One iteration step for both algorithms, then final sign fix-up
    always_comb begin
        // Shift-add: add multiplicand when the multiplier LSB is set, shift right
        w_mul_sum    = {1'b0, r_acc} + (r_shf[0] ? {1'b0, r_a} : '0);
        // Restoring divide: shift in next dividend bit, trial-subtract divisor.
        // The shifted remainder is below 2*divisor, so the MSB of the W+1 bit
        // difference is a clean borrow flag.
        w_div_rem_sh = {r_acc, r_shf[WIDTH-1]};
        w_div_diff   = w_div_rem_sh - {1'b0, r_a};
        w_div_ge     = ~w_div_diff[WIDTH];

        if (r_op_div) begin
            w_nxt_acc = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_rem_sh[WIDTH-1:0];
            w_nxt_shf = {r_shf[WIDTH-2:0], w_div_ge};
        end else begin
            w_nxt_acc = w_mul_sum[WIDTH:1];
            w_nxt_shf = {w_mul_sum[0], r_shf[WIDTH-1:1]};
        end

        w_prod = {w_nxt_acc, w_nxt_shf};
        if (r_div0) begin
            // Divide by zero reports the untouched dividend and an all-ones quotient
            w_fin_hi = r_src1;
            w_fin_lo = '1;
        end else if (r_op_div) begin
            w_fin_hi = r_sign_r ? -w_nxt_acc : w_nxt_acc;
            w_fin_lo = r_sign_q ? -w_nxt_shf : w_nxt_shf;
        end else begin
            w_prod   = r_sign_q ? -w_prod : w_prod;
            w_fin_hi = w_prod[2*WIDTH-1:WIDTH];
            w_fin_lo = w_prod[WIDTH-1:0];
        end
    end

    // Control FSM, iteration datapath and HI/LO result registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state  <= c_IDLE;
            r_cnt    <= '0;
            r_op_div <= 1'b0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_div0   <= 1'b0;
            r_src1   <= '0;
            r_a      <= '0;
            r_acc    <= '0;
            r_shf    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (w_accept) begin
                        r_op_div <= op_i[1];
                        r_sign_q <= op_i[0] & (src1_i[WIDTH-1] ^ src2_i[WIDTH-1]);
                        r_sign_r <= op_i[0] & src1_i[WIDTH-1];
                        r_div0   <= op_i[1] & (src2_i == '0);
                        r_src1   <= src1_i;
                        r_a      <= op_i[1] ? w_abs2 : w_abs1;
                        r_shf    <= op_i[1] ? w_abs1 : w_abs2;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_state  <= c_RUN;
                    end else begin
                        r_state  <= c_IDLE;
                    end
                end
                c_RUN: begin
                    r_acc <= w_nxt_acc;
                    r_shf <= w_nxt_shf;
                    r_cnt <= r_cnt + c_CNT_ONE;
                    if (r_cnt == c_LAST) begin
                        r_hi    <= w_fin_hi;
                        r_lo    <= w_fin_lo;
                        r_state <= c_DONE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign busy_o   = (r_state == c_RUN);
    assign done_o   = (r_state == c_DONE);
    assign hi_o     = r_hi;
    assign lo_o     = r_lo;
    assign result_o = hilo_sel_i ? r_hi : r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_mult_div_unit
//  Purpose  : Self-checking bench for mult_div_unit with a result scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        hilo_sel;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] result;

    typedef struct {
        logic [63:0] exp;
        longint      t0;
    } sb_t;

    sb_t sb_q[$];
    int  n_tests  = 0;
    int  n_fail   = 0;
    int  busy_cnt = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .op_i       (op),
        .src1_i     (src1),
        .src2_i     (src2),
        .hilo_sel_i (hilo_sel),
        .busy_o     (busy),
        .done_o     (done),
        .hi_o       (hi),
        .lo_o       (lo),
        .result_o   (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference {HI,LO} computed with wide native arithmetic
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] q;
        logic signed [63:0] r;
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
        case (o)
            2'b00:   model = {32'b0, a} * {32'b0, b};
            2'b01:   model = sa * sb;
            default: begin
                if (b == 32'd0) begin
                    model = {a, 32'hFFFF_FFFF};
                end else if (o == 2'b10) begin
                    model = {a % b, a / b};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    model = {r[31:0], q[31:0]};
                end
            end
        endcase
    endfunction

    // Drive one request; caller is positioned just after a rising edge
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit expect_done);
        sb_t e;
        start = 1'b1;
        op    = o;
        src1  = a;
        src2  = b;
        @(posedge clk);
        e.t0  = $time;
        e.exp = model(o, a, b);
        if (expect_done) sb_q.push_back(e);
        #1;
        start = 1'b0;
        op    = 2'($urandom);
        src1  = $urandom;
        src2  = $urandom;
    endtask

    // Returns just after the edge that raised done_o (bounded)
    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        if (!seen) check("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic gap();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: compare every completion against the oldest request
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                busy_cnt = 0;
            end else begin
                if (busy) busy_cnt++;
                if (done) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_done", 64'd1, 64'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check("hi", 64'(hi), 64'(e.exp[63:32]));
                        check("lo", 64'(lo), 64'(e.exp[31:0]));
                        check("latency", 64'($time - e.t0), 64'd325);
                        check("busy_cycles", 64'(busy_cnt), 64'd32);
                        check("busy_in_done", 64'(busy), 64'd0);
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        rst      = 1'b0;
        start    = 1'b0;
        op       = 2'b00;
        src1     = '0;
        src2     = '0;
        hilo_sel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rst = 1'b1;
        gap();

        issue(2'b00, 32'hFFFF_FFFF, 32'h2, 1'b1);
        wait_done();
        check("multu_hi", 64'(hi), 64'h1);
        check("multu_lo", 64'(lo), 64'hFFFF_FFFE);
        gap();

        issue(2'b01, 32'hFFFF_FFFD, 32'h5, 1'b1);
        wait_done();
        hilo_sel = 1'b0;
        #1 check("result_lo", 64'(result), 64'hFFFF_FFF1);
        hilo_sel = 1'b1;
        #1 check("result_hi", 64'(result), 64'hFFFF_FFFF);
        hilo_sel = 1'b0;
        gap();

        issue(2'b11, 32'hFFFF_FFF9, 32'h2, 1'b1);
        wait_done();
        check("div_lo", 64'(lo), 64'hFFFF_FFFD);
        check("div_hi", 64'(hi), 64'hFFFF_FFFF);
        gap();
        issue(2'b10, 32'd100, 32'd7, 1'b1);
        wait_done();
        gap();
        issue(2'b10, 32'hA, 32'h0, 1'b1);
        wait_done();
        gap();
        issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_done();
        gap();
        issue(2'b11, 32'hFFFF_FFF9, 32'h0, 1'b1);
        wait_done();
        gap();

        // start pulse mid-RUN with new operands must be ignored
        issue(2'b10, 32'd1000, 32'd3, 1'b1);
        repeat (9) @(posedge clk);
        #1;
        start = 1'b1;
        op    = 2'b01;
        src1  = 32'd5;
        src2  = 32'd5;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done();

        // back-to-back: start held in the DONE cycle
        issue(2'b01, 32'd12345, 32'hFFFF_E57B, 1'b1);
        wait_done();
        issue(2'b11, 32'h7FFF_FFFF, 32'h10, 1'b1);
        wait_done();
        gap();

        for (int i = 0; i < 8; i++) begin
            ro = 2'($urandom);
            ra = $urandom;
            rb = (i == 3) ? 32'd0 : $urandom;
            if (ro[1] && i[0]) rb = rb >> 20;
            issue(ro, ra, rb, 1'b1);
            wait_done();
            if (i[1]) gap();
        end
        gap();

        // asynchronous reset mid-RUN aborts and clears
        issue(2'b00, 32'd7, 32'd9, 1'b0);
        repeat (15) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("post_reset_done", 64'(done), 64'd0);
        check("post_reset_busy", 64'(busy), 64'd0);

        issue(2'b10, 32'd100, 32'd7, 1'b1);
        wait_done();
        gap();
        #20;
        check("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
